tdc_fifo_reader: RTL
====================

# tdc_fifo_reader

Consumer for the TDC core's 8-bit readout FIFO. It pops bytes using the `fifo_data_available` / `read_fifo` handshake, packs a fixed number of bytes into one timestamp word, and presents the word on a valid/ready stream toward the host-side logic. It sits between the TDC core's FIFO port and the readout/serialiser, in the `SYSCLK` domain.

## Interface
- `BYTES_PER_WORD`, default 3: bytes packed per output word; legal range 2..8.
- `SYSCLK` input 1: sole clock; everything is rising-edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `fifo_data_available` input 1: TDC FIFO is non-empty.
- `read_fifo` output 1: one-cycle pop strobe to the TDC FIFO.
- `fifo_dout` input 8: FIFO data, valid in the cycle after `read_fifo`.
- `word_data` output 8*BYTES_PER_WORD: assembled word; the first byte read is in bits [7:0].
- `word_valid` output 1: `word_data` holds a complete word.
- `word_ready` input 1: downstream accepts the word while `word_valid` is high.
- `word_count` output 16: number of accepted words, wraps at 0xFFFF→0.
- `sync_errors` output 8: frame resyncs, saturates at 0xFF. Present only with `TDC_READER_SYNC_EN`.

## Operation
- FSM states:
  - `S_IDLE`: if `fifo_data_available`, assert `read_fifo` for one cycle and go to `S_CAPTURE`.
  - `S_CAPTURE`: sample `fifo_dout` into byte slot `idx`.
    - If `idx==BYTES_PER_WORD-1`, load `word_data`, set `word_valid`, and go to `S_HOLD`.
    - Otherwise `idx++` and go to `S_IDLE`.
  - `S_HOLD`: hold `word_data` and `word_valid` stable. On `word_valid && word_ready`, clear `word_valid`, `idx←0`, `word_count++`, and go to `S_IDLE`.
- The reader never asserts `read_fifo` in `S_CAPTURE` or `S_HOLD`. At most one pop is outstanding.
- Assembly register: byte slot `idx` is written at bits [8*idx+7 : 8*idx]. `word_data` is a registered copy taken on the final byte.
- `read_fifo` is never asserted while `fifo_data_available==0`.
- Backpressure: while in `S_HOLD`, FIFO bytes stay in the TDC FIFO. No byte is dropped.
- `word_count` increments only on a completed handshake.

## Timing
- Reset values: `read_fifo`=0, `word_valid`=0, `word_data`=0, `word_count`=0, `sync_errors`=0, `idx`=0, state `S_IDLE`.
- Byte throughput: 1 byte per 2 cycles (pop, capture).
- Latency, with the FIFO continuously available: from the first `read_fifo` to `word_valid` high is 2*BYTES_PER_WORD cycles.
- After a handshake in cycle N, the next `read_fifo` can occur at cycle N+1 at the earliest.
- `word_ready` high with `word_valid` low has no effect.
- `word_ready` held high in `S_HOLD`: the handshake completes on the first `S_HOLD` cycle.
- `RESET_N` low mid-word or mid-hold:
  - All state clears asynchronously and the partial word is discarded.
  - A byte popped in the same cycle as the reset is lost, which is acceptable.
- `fifo_data_available` dropping while in `S_CAPTURE`: the capture still completes, because data was already popped.

## Configuration
- `TDC_READER_SYNC_EN` defined: `fifo_dout[7]` is a frame-start marker.
  - In `S_CAPTURE` with `idx==0` and bit7=0: discard the byte, stay at `idx=0`, increment `sync_errors`.
  - With `idx>0` and bit7=1: discard the partial word, store this byte as slot 0, set `idx←1`, increment `sync_errors`.
  - `sync_errors` saturates at 255.
- `TDC_READER_SYNC_EN` undefined: bytes are grouped purely by count, bit7 is ordinary data, and the `sync_errors` port and logic are absent.

## Structure
- Package `tdc_reader_pkg` holds:
  - the FSM state enum `tdc_reader_state_t` (`S_IDLE`, `S_CAPTURE`, `S_HOLD`);
  - `TDC_BYTE_W`=8;
  - `TDC_WCOUNT_W`=16;
  - `TDC_SYNC_MARK_BIT`=7.
- One sub-module: `sat_counter`, a parameterised-width saturating incrementer used for `sync_errors`.
- Everything else lives inline in `tdc_fifo_reader`.

## Test plan
- `BYTES_PER_WORD`=3, FIFO preloaded 0x81,0x22,0x33, `word_ready`=1: expect `word_data`=0x332281 with `word_valid` high exactly 6 cycles after the first `read_fifo`; `word_count`=1; exactly 3 `read_fifo` pulses.
- Same data with `word_ready`=0 for 10 cycles and 3 more bytes in the FIFO: `word_data` is stable and there is no `read_fifo` during the hold. After `word_ready`=1, the next word follows and `word_count`=2.
- FIFO empty with `word_ready` toggling: `read_fifo` and `word_valid` stay 0 and `word_count` stays 0.
- `RESET_N` pulsed low after 2 of 3 bytes, then bytes 0x8A,0x0B,0x0C: expect `word_data`=0x0C0B8A; no remnant of the old bytes.
- With `TDC_READER_SYNC_EN`, bytes 0x05,0x81,0x02,0x83,0x04,0x05: expect 0x05 discarded, then the partial 0x81,0x02 aborted by 0x83, then output 0x050483, `sync_errors`=2.
- Drive `word_count` to 0xFFFF, then complete one word: `word_count` reads 0x0000.

Source files
------------

// File: rtl/tdc_reader_pkg.sv
// Shared types and constants for the TDC FIFO reader.
// Optional frame sync is enabled by defining TDC_READER_SYNC_EN.
package tdc_reader_pkg;

  localparam int TDC_BYTE_W        = 8;
  localparam int TDC_WCOUNT_W      = 16;
  localparam int TDC_SYNC_MARK_BIT = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HOLD
  } tdc_reader_state_t;

endpackage

// File: rtl/tdc_fifo_reader_sat_counter.sv
// Saturating incrementer, used for the resync error count.
// Only built when TDC_READER_SYNC_EN is defined.
`ifdef TDC_READER_SYNC_EN
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/tdc_fifo_reader.sv
// Pops TDC readout FIFO bytes and packs them into valid/ready words.
// TDC_READER_SYNC_EN: bit 7 of each byte marks the start of a frame.
module tdc_fifo_reader
  import tdc_reader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 3
) (
  input  logic                                SYSCLK,
  input  logic                                RESET_N,
  input  logic                                fifo_data_available,
  output logic                                read_fifo,
  input  logic [TDC_BYTE_W-1:0]               fifo_dout,
  output logic [TDC_BYTE_W*BYTES_PER_WORD-1:0] word_data,
  output logic                                word_valid,
  input  logic                                word_ready,
`ifdef TDC_READER_SYNC_EN
  output logic [7:0]                          sync_errors,
`endif
  output logic [TDC_WCOUNT_W-1:0]             word_count
);

  localparam int WORD_W = TDC_BYTE_W * BYTES_PER_WORD;
  localparam int IDX_W  = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(BYTES_PER_WORD - 1);

  tdc_reader_state_t state, state_d;

  logic [IDX_W-1:0]  idx, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              load;
  logic              accept;
  logic              take;
  logic              sync_inc;

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    asm_d     = asm_q;
    read_fifo = 1'b0;
    load      = 1'b0;
    accept    = 1'b0;
    take      = 1'b0;
    sync_inc  = 1'b0;
    unique case (state)
      S_IDLE: begin
        // Reset gating keeps the pop strobe low while held in reset.
        if (fifo_data_available && RESET_N) begin
          read_fifo = 1'b1;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        take    = 1'b1;
`ifdef TDC_READER_SYNC_EN
        if ((idx == '0) && !fifo_dout[TDC_SYNC_MARK_BIT]) begin
          take     = 1'b0;
          sync_inc = 1'b1;
        end else if ((idx != '0) && fifo_dout[TDC_SYNC_MARK_BIT]) begin
          // New frame start mid-word: restart with this byte in slot 0.
          take     = 1'b0;
          sync_inc = 1'b1;
          asm_d    = WORD_W'(fifo_dout);
          idx_d    = IDX_W'(1);
        end
`endif
        if (take) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx == IDX_W'(i)) begin
              asm_d[TDC_BYTE_W*i +: TDC_BYTE_W] = fifo_dout;
            end
          end
          if (idx == IDX_LAST) begin
            load    = 1'b1;
            state_d = S_HOLD;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (word_valid && word_ready) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      idx   <= '0;
      asm_q <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      asm_q <= asm_d;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      word_data  <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else begin
      if (load) begin
        word_data  <= asm_d;
        word_valid <= 1'b1;
      end else if (accept) begin
        word_valid <= 1'b0;
      end
      if (accept) begin
        word_count <= word_count + 1'b1;
      end
    end
  end

`ifdef TDC_READER_SYNC_EN
  sat_counter #(
    .W(8)
  ) u_sync_cnt (
    .clk  (SYSCLK),
    .rst_n(RESET_N),
    .inc  (sync_inc),
    .count(sync_errors)
  );
`else
  logic unused_sync;
  assign unused_sync = sync_inc ^ take;
`endif

endmodule
